// File: rtl/tile_writeback.sv
// Tile color buffer: captures renderer pixel writes into a 32x32x16 RAM and,
// on flush, streams the tile row-major to the framebuffer port with
// valid/ready handshaking through a 2-entry skid buffer.
module tile_writeback #(
  parameter int FB_STRIDE = 640,
  parameter int ADDR_W    = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        X,
  input  logic [4:0]        Y,
  input  logic              wren,
  input  logic [15:0]       color_in,
  input  logic              flush,
  input  logic [ADDR_W-1:0] tile_base,
  output logic              busy,
  output logic              done,
  output logic              wr_overrun,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_data,
  output logic              mem_last
);

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  state_t state, state_nxt;

  logic [15:0]       buf_mem [1024];
  logic [15:0]       rd_data;
  logic              rd_pend;     // RAM output holds a beat this cycle
  logic [9:0]        iss_idx;     // {row,col} of next read to issue
  logic              iss_all;     // all 1024 reads issued
  logic [15:0]       skid [2];
  logic              wr_ptr, rd_ptr;
  logic [1:0]        cnt;         // skid occupancy
  logic [1:0]        occ;         // skid occupancy plus in-flight read
  logic [ADDR_W-1:0] row_base;
  logic [4:0]        out_row, out_col;

  logic flush_acc, pop, last_beat, issue;

  assign flush_acc = flush && (state == IDLE);
  assign pop       = mem_valid && mem_ready;
  assign last_beat = pop && (out_row == 5'd31) && (out_col == 5'd31);
  assign occ       = cnt + {1'b0, rd_pend};
  // Issue only if the read lands in a free slot, counting a pop this cycle.
  assign issue     = (state == STREAM) && !iss_all &&
                     ((occ < 2'd2) || ((occ == 2'd2) && pop));

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (flush) state_nxt = STREAM;
      STREAM:  if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Buffer write port: renderer writes land only while idle
  always_ff @(posedge clk) begin
    if (wren && (state == IDLE)) buf_mem[{Y, X}] <= color_in;
  end

  // Buffer read port, 1-cycle latency
  always_ff @(posedge clk) begin
    if (issue) rd_data <= buf_mem[iss_idx];
  end

  // Read issue counter and read-valid tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_idx <= '0;
      iss_all <= 1'b0;
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= issue;
      if (flush_acc) begin
        iss_idx <= '0;
        iss_all <= 1'b0;
      end else if (issue) begin
        iss_idx <= iss_idx + 10'd1;
        if (iss_idx == 10'd1023) iss_all <= 1'b1;
      end
    end
  end

  // Skid buffer: absorbs RAM data so the stream survives ready stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      skid[0] <= '0;
      skid[1] <= '0;
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      cnt     <= '0;
    end else begin
      if (rd_pend) begin
        skid[wr_ptr] <= rd_data;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, rd_pend} - {1'b0, pop};
    end
  end

  // Output-side position and framebuffer row address (stride add, no multiply)
  always_ff @(posedge clk) begin
    if (rst) begin
      row_base <= '0;
      out_row  <= '0;
      out_col  <= '0;
    end else if (flush_acc) begin
      row_base <= tile_base;
      out_row  <= '0;
      out_col  <= '0;
    end else if (pop) begin
      out_col <= out_col + 5'd1;
      if (out_col == 5'd31) begin
        out_row  <= out_row + 5'd1;
        row_base <= row_base + ADDR_W'(FB_STRIDE);
      end
    end
  end

  // Sticky overrun: renderer wrote while the tile was draining
  always_ff @(posedge clk) begin
    if (rst)                         wr_overrun <= 1'b0;
    else if (flush_acc)              wr_overrun <= 1'b0;
    else if (wren && state != IDLE)  wr_overrun <= 1'b1;
  end

  assign busy      = (state == STREAM);
  assign done      = (state == DONE);
  assign mem_valid = (cnt != 2'd0);
  assign mem_data  = skid[rd_ptr];
  assign mem_addr  = row_base + ADDR_W'(out_col);
  assign mem_last  = mem_valid && (out_col == 5'd31);

endmodule

// File: tb/tb_tile_writeback.sv
// Randomized self-checking bench for tile_writeback against a tile-array model.
module tb_tile_writeback;
  localparam int FB = 640;
  localparam int AW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [4:0]    X, Y;
  logic          wren;
  logic [15:0]   color_in;
  logic          flush;
  logic [AW-1:0] tile_base;
  logic          busy, done, wr_overrun, mem_valid, mem_ready, mem_last;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;

  int n_chk = 0;
  int n_err = 0;

  logic [15:0]   ref_buf [1024];
  logic [AW-1:0] cur_base;

  always #5 clk = ~clk;

  tile_writeback #(.FB_STRIDE(FB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .X(X), .Y(Y), .wren(wren), .color_in(color_in),
    .flush(flush), .tile_base(tile_base), .busy(busy), .done(done),
    .wr_overrun(wr_overrun), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_last(mem_last)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] base, input int idx);
    return base + AW'(FB * (idx / 32)) + AW'(idx % 32);
  endfunction

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovr"},  wr_overrun, 0);
    chk({tag, "_vld"},  mem_valid, 0);
    chk({tag, "_last"}, mem_last, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_data"}, mem_data, 0);
  endtask

  task automatic write_px(input int x, input int y, input logic [15:0] c);
    X = 5'(x); Y = 5'(y); color_in = c; wren = 1'b1;
    step();
    wren = 1'b0;
    ref_buf[y*32 + x] = c;
  endtask

  task automatic fill(input bit rnd);
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 32; x++)
        write_px(x, y, rnd ? 16'($urandom) : {5'(y), 5'(x), 6'b0});
  endtask

  task automatic do_flush(input logic [AW-1:0] base);
    tile_base = base; flush = 1'b1;
    step();
    flush = 1'b0;
    cur_base = base;
    chk("flush_busy", busy, 1);
    chk("flush_ovr_clr", wr_overrun, 0);
    chk("flush_no_early_vld", mem_valid, 0);
  endtask

  // Drain one tile; inj>=0 pulses a busy-time wren then a second flush,
  // rst_at>=0 asserts reset right after that many beats complete.
  task automatic run_stream(input bit rnd, input int inj, input int rst_at);
    int beats = 0;
    int cyc = 0;
    int first = -1;
    bit stall = 0;
    logic [AW-1:0] p_addr;
    logic [15:0]   p_data;
    logic          p_last;
    while (beats < 1024 && cyc < 20000) begin
      if (mem_valid) begin
        if (first < 0) begin
          first = cyc;
          chk("first_lat_ok", (cyc >= 1 && cyc <= 2), 1);
        end
        if (stall) begin
          chk("stall_addr", mem_addr, p_addr);
          chk("stall_data", mem_data, p_data);
          chk("stall_last", mem_last, p_last);
        end
        chk("beat_addr", mem_addr, exp_addr(cur_base, beats));
        chk("beat_data", mem_data, ref_buf[beats]);
        chk("beat_last", mem_last, (beats % 32) == 31);
      end else begin
        if (stall) chk("valid_dropped", mem_valid, 1);
        if (!rnd && first >= 0) chk("bubble", mem_valid, 1);
      end
      mem_ready = rnd ? 1'($urandom) : 1'b1;
      if (inj >= 0) begin
        wren = (cyc == inj);
        X = 5'd3; Y = 5'd3; color_in = 16'hFFFF;
        flush = (cyc == inj + 1);
        tile_base = (cyc == inj + 1) ? 24'h123456 : cur_base;
      end
      stall  = mem_valid && !mem_ready;
      p_addr = mem_addr; p_data = mem_data; p_last = mem_last;
      if (mem_valid && mem_ready) beats++;
      step();
      cyc++;
      wren = 1'b0; flush = 1'b0;
      if (rst_at >= 0 && beats == rst_at) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_reset("midrst");
        return;
      end
    end
    chk("stream_complete", beats, 1024);
    chk("done_pulse", done, 1);
    chk("done_busy", busy, 0);
    chk("done_vld", mem_valid, 0);
    step();
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    rst = 1'b1; X = '0; Y = '0; wren = 1'b0; color_in = '0;
    flush = 1'b0; tile_base = '0; mem_ready = 1'b0; cur_base = '0;
    step();
    chk_reset("reset");
    step();
    rst = 1'b0;
    step();

    // Pattern tile at 0x1000, full-rate drain
    fill(0);
    do_flush(24'h001000);
    run_stream(0, -1, -1);
    step();

    // Same tile, random backpressure
    do_flush(24'h001000);
    run_stream(1, -1, -1);
    step();

    // Random colors, last write wins, address wrap at top of space
    fill(1);
    write_px(9, 4, 16'h1111);
    write_px(9, 4, 16'h2222);
    do_flush(24'hFFFFF0);
    run_stream(1, -1, -1);
    step();

    // Busy-time write dropped and mid-stream flush ignored
    do_flush(24'h004000);
    run_stream(0, 10, -1);
    chk("overrun_set", wr_overrun, 1);
    step();

    // wren and flush in the same idle cycle
    X = 5'd0; Y = 5'd0; color_in = 16'hABCD; wren = 1'b1;
    ref_buf[0] = 16'hABCD;
    do_flush(24'h020000);
    wren = 1'b0;
    run_stream(0, -1, -1);
    step();

    // Reset after 100 beats, then restart with a new base
    do_flush(24'h030000);
    run_stream(1, -1, 100);
    fill(1);
    do_flush(24'h0ABCDE);
    run_stream(1, -1, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/tile_writeback.md
# tile_writeback

Tile color-buffer and write-out engine sitting directly downstream of the tile renderer. It captures the renderer's per-pixel color writes into a local 32x32x16 on-chip buffer. On `flush` it streams the finished tile in row-major order to the framebuffer memory port, one 16-bit pixel per beat, using a valid/ready handshake. Each beat carries a linear framebuffer pixel address.

## Interface
Parameters:
- FB_STRIDE, 640, framebuffer row pitch in pixels
- ADDR_W, 24, width of framebuffer pixel address

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- X  in  5  pixel column within tile, from renderer
- Y  in  5  pixel row within tile, from renderer
- wren  in  1  write color_in to buffer[Y][X] this cycle
- color_in  in  16  RGB565 pixel color
- flush  in  1  one-cycle request to stream the tile out
- tile_base  in  ADDR_W  framebuffer address of tile pixel (0,0); sampled on accepted flush
- busy  out  1  streaming in progress
- done  out  1  one-cycle pulse when the tile has been fully written out
- wr_overrun  out  1  sticky flag: a wren arrived while busy
- mem_valid  out  1  beat valid
- mem_ready  in  1  memory accepts the beat
- mem_addr  out  ADDR_W  pixel address of beat
- mem_data  out  16  pixel color of beat
- mem_last  out  1  beat is column 31 of a row

## Operation
- Buffer: 1024x16 simple dual-port RAM; address = {Y,X}; synchronous read with 1-cycle latency; contents are not initialised by reset and are not cleared by flush.
- States:
  - IDLE: wren writes the buffer. A flush latches tile_base into row_base, zeroes row/col counters, clears wr_overrun, and moves to STREAM.
  - STREAM: issues buffer reads and presents beats; a beat completes on mem_valid && mem_ready. After the completed beat at (31,31), moves to DONE.
  - DONE: asserts done for one cycle, then returns to IDLE.
- Read pipeline: 1-cycle RAM latency plus a 2-entry skid buffer. Reads are issued only when the skid has room, so a full-rate stream is sustained under continuous mem_ready.
- Address arithmetic:
  - mem_addr = row_base + col, modulo 2^ADDR_W.
  - row_base += FB_STRIDE when a row's last beat completes, modulo 2^ADDR_W.
  - No multiplier is used.
- Order: row 0..31 outer, col 0..31 inner; mem_last = (col == 31).
- wren while busy (STREAM or DONE): the write is dropped and wr_overrun is set. wr_overrun stays set until the next accepted flush.
- flush while busy: ignored, with no effect on the stream or on tile_base.
- wren and flush in the same IDLE cycle: the write commits and the streamed tile includes it.
- wren with the same {Y,X} in consecutive cycles: the last write wins.

## Timing
- Reset values: busy=0, done=0, wr_overrun=0, mem_valid=0, mem_last=0, mem_addr=0, mem_data=0; state=IDLE.
- Flush accepted at edge t: busy=1 from t+1; first mem_valid no earlier than t+2 and no later than t+3.
- With mem_ready held at 1: one beat per cycle, 1024 consecutive beats, no bubbles after the first.
- While mem_valid=1 and mem_ready=0: mem_addr, mem_data and mem_last hold stable and mem_valid stays 1.
- mem_valid never drops without a completed handshake.
- Final handshake at edge f: done=1 and busy=0 during cycle f+1; a new flush is accepted from edge f+2.
- Reset asserted mid-stream: at the next edge all outputs take reset values, the in-flight skid data is discarded, and buffer contents are undefined.

## Test plan
- Write color = {Y,X,6'b0} to all 1024 pixels, tile_base=0x001000, FB_STRIDE=640, ready=1, then flush:
  - 1024 beats in row-major order.
  - beat (r,c): addr=0x1000+640r+c, data={r,c,6'b0}, mem_last at every c=31.
  - done exactly one cycle after the last handshake.
- Same stream with mem_ready toggling pseudo-randomly at 50%:
  - identical beat sequence.
  - no beat lost or duplicated.
  - addr, data and last stable during every stall.
- tile_base = 2^24-16: addresses wrap modulo 2^24; row 0 col 16 has addr=0x000000.
- Pulse wren at cycle 10 of streaming (X=3,Y=3, color 0xFFFF), then issue a second flush mid-stream:
  - wr_overrun=1.
  - beat (3,3) carries the pre-flush color.
  - the second flush has no effect.
  - the next accepted flush clears wr_overrun.
- wren (X=0,Y=0, 0xABCD) and flush in the same cycle: the first beat has data=0xABCD and addr=tile_base.
- Assert rst for one cycle after 100 beats, then flush:
  - all outputs return to reset values on the next edge.
  - the new flush restarts at row 0 col 0 with the new tile_base.
